// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge and its two memory slaves.
package apb_pkg;

    // Full address width: MSB selects the slave, the rest is the word address.
    localparam int AW = 9;
    // Data width of every APB data path.
    localparam int DW = 8;
    // Word address width inside one slave memory.
    localparam int MEM_AW = AW - 1;
    // Number of words in one slave memory.
    localparam int MEM_DEPTH = 1 << MEM_AW;

    // Master bridge states.
    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    // True when the address targets slave 2 (address MSB set).
    function automatic logic is_slave2(input logic [AW-1:0] addr);
        return addr[AW-1];
    endfunction

endpackage

// File: rtl/apb_mem_slave.sv
// Zero-wait-state APB slave backed by a 256x8 memory, cleared on reset.
// Handshake: a transfer is accepted on the clock edge where PSEL, PENABLE and
// PREADY are all high; this slave drives PREADY high whenever PSEL&PENABLE,
// so every ACCESS phase completes on its first edge.
module apb_mem_slave
    import apb_pkg::*;
(
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [MEM_AW-1:0] PADDR,
    input  logic [DW-1:0]     PWDATA,
    output logic [DW-1:0]     PRDATA,
    output logic              PREADY
);

    logic [DW-1:0] mem_q [MEM_DEPTH];
    logic          access;
    logic          wr_en;
    logic          rd_en;

    // Decode the ACCESS phase into write and read strobes.
    always_comb begin
        access = PSEL & PENABLE;
        wr_en  = access & PWRITE;
        rd_en  = access & ~PWRITE;
        PREADY = access;
    end

    // Read data is combinational during a read ACCESS and zero otherwise, so
    // an unselected slave never disturbs the master's read mux.
    always_comb begin
        PRDATA = '0;
        if (rd_en) begin
            PRDATA = mem_q[PADDR];
        end
    end

    // Memory array: cleared by reset, written on the ACCESS edge of a write.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[PADDR] <= PWDATA;
        end
    end

endmodule

// File: rtl/apb_modport.sv
// APB subsystem: a master bridge turning host transfer requests into APB
// SETUP/ACCESS cycles, driving two independent 256x8 memory slaves.
// Address bit 8 selects the slave (0 -> slave 1, 1 -> slave 2).
// Host handshake: a request (READ_WRITE, addresses, write data) is taken on
// every edge where transfer=1 and the bridge is in IDLE, or in ACCESS with
// PREADY=1; inputs at any other edge are ignored by the transfer in flight.
// The FSM state is held in state_q for observation.
module apb_modport
    import apb_pkg::*;
(
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          transfer,
    input  logic          READ_WRITE,
    input  logic [AW-1:0] apb_read_paddr,
    input  logic [AW-1:0] apb_write_paddr,
    input  logic [DW-1:0] apb_write_data,
    output logic [DW-1:0] apb_read_data_out
);

    // Master state and the captured request.
    apb_state_e    state_q,  state_d;
    logic          pwrite_q, pwrite_d;
    logic [AW-1:0] paddr_q,  paddr_d;
    logic [DW-1:0] pwdata_q, pwdata_d;
    logic [DW-1:0] rdata_q,  rdata_d;

    // APB bus towards the slaves.
    logic          sel;
    logic          psel1;
    logic          psel2;
    logic          penable;
    logic          pready1;
    logic          pready2;
    logic          pready;
    logic [DW-1:0] prdata1;
    logic [DW-1:0] prdata2;
    logic [DW-1:0] prdata;
    logic          addr_hi;

    // Bus control is a pure decode of the registered state and address, so
    // the APB signals are glitch-free and hold steady while ACCESS waits.
    always_comb begin
        addr_hi = is_slave2(paddr_q);
        sel     = (state_q == SETUP) || (state_q == ACCESS);
        penable = (state_q == ACCESS);
        psel1   = sel & ~addr_hi;
        psel2   = sel & addr_hi;
    end

    // Return path: ready and read data follow the slave picked by the address MSB.
    always_comb begin
        pready = addr_hi ? pready2 : pready1;
        prdata = addr_hi ? prdata2 : prdata1;
    end

    // Next-state logic: request capture, FSM sequencing and read-data latch.
    always_comb begin
        state_d  = state_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d  = SETUP;
                    pwrite_d = READ_WRITE;
                    paddr_d  = READ_WRITE ? apb_write_paddr : apb_read_paddr;
                    pwdata_d = apb_write_data;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    // Only a completing read updates the host-visible data.
                    if (!pwrite_q) begin
                        rdata_d = prdata;
                    end
                    if (transfer) begin
                        state_d  = SETUP;
                        pwrite_d = READ_WRITE;
                        paddr_d  = READ_WRITE ? apb_write_paddr : apb_read_paddr;
                        pwdata_d = apb_write_data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Master registers; reset abandons any transfer that has not completed.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
        end
    end

    assign apb_read_data_out = rdata_q;

    apb_mem_slave u_slave1 (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (psel1),
        .PENABLE (penable),
        .PWRITE  (pwrite_q),
        .PADDR   (paddr_q[MEM_AW-1:0]),
        .PWDATA  (pwdata_q),
        .PRDATA  (prdata1),
        .PREADY  (pready1)
    );

    apb_mem_slave u_slave2 (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (psel2),
        .PENABLE (penable),
        .PWRITE  (pwrite_q),
        .PADDR   (paddr_q[MEM_AW-1:0]),
        .PWDATA  (pwdata_q),
        .PRDATA  (prdata2),
        .PREADY  (pready2)
    );

endmodule

// File: tb/tb_apb_modport.sv
// Self-checking bench for apb_modport: directed transfers, expected read data
// queued at issue time and compared by an independent monitor.
module tb_apb_modport;
  import apb_pkg::*;

  logic          PCLK;
  logic          PRESETn;
  logic          transfer;
  logic          READ_WRITE;
  logic [AW-1:0] apb_read_paddr;
  logic [AW-1:0] apb_write_paddr;
  logic [DW-1:0] apb_write_data;
  logic [DW-1:0] apb_read_data_out;

  int checks;
  int errors;
  logic [DW-1:0] exp_q[$];

  apb_modport dut (
    .PCLK              (PCLK),
    .PRESETn           (PRESETn),
    .transfer          (transfer),
    .READ_WRITE        (READ_WRITE),
    .apb_read_paddr    (apb_read_paddr),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_data_out (apb_read_data_out)
  );

  // ---------------- clock / reset ----------------
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout need finish");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h need 0x%0h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present one request at a negedge; it is sampled on the following posedge.
  task automatic drive_req(input logic rw, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd);
    transfer   = 1'b1;
    READ_WRITE = rw;
    if (rw) begin
      apb_write_paddr = addr;
      apb_read_paddr  = 9'h1FF;
    end else begin
      apb_read_paddr  = addr;
      apb_write_paddr = 9'h1FF;
    end
    apb_write_data = wdata;
    if (!rw) exp_q.push_back(exp_rd);
  endtask

  // Single isolated transfer with bus/state checks in SETUP and ACCESS.
  task automatic single_xfer(input string name, input logic rw, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd);
    logic hi;
    hi = addr[AW-1];
    @(negedge PCLK);
    drive_req(rw, addr, wdata, exp_rd);
    @(posedge PCLK);
    @(negedge PCLK);
    transfer = 1'b0;
    // Scramble inputs: they must not affect the transfer in flight.
    READ_WRITE      = ~rw;
    apb_read_paddr  = 9'h0F0;
    apb_write_paddr = 9'h0F0;
    apb_write_data  = 8'hEE;
    check({name, "_setup_state"}, 32'(dut.state_q), 32'(SETUP));
    check({name, "_setup_psel"}, {30'd0, dut.psel2, dut.psel1}, {30'd0, hi, ~hi});
    check({name, "_setup_penable"}, 32'(dut.penable), 32'd0);
    @(negedge PCLK);
    check({name, "_access_state"}, 32'(dut.state_q), 32'(ACCESS));
    check({name, "_access_psel"}, {30'd0, dut.psel2, dut.psel1}, {30'd0, hi, ~hi});
    check({name, "_access_penable"}, 32'(dut.penable), 32'd1);
    @(negedge PCLK);
    check({name, "_idle_state"}, 32'(dut.state_q), 32'(IDLE));
  endtask

  // ---------------- scoreboard monitor ----------------
  // A read completes on the edge following a negedge that sees ACCESS,
  // read direction and PREADY; the data is compared just after that edge.
  always @(negedge PCLK) begin
    if (PRESETn && dut.state_q == ACCESS && !dut.pwrite_q && dut.pready) begin
      @(posedge PCLK);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_unexpected: got 0x%0h need no read", apb_read_data_out);
      end else begin
        check("read_data", 32'(apb_read_data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] b2b_data [4];

  initial begin
    checks = 0;
    errors = 0;
    b2b_data[0] = 8'h11;
    b2b_data[1] = 8'h22;
    b2b_data[2] = 8'h33;
    b2b_data[3] = 8'h44;
    PRESETn = 1'b0;
    transfer = 1'b0;
    READ_WRITE = 1'b0;
    apb_read_paddr = '0;
    apb_write_paddr = '0;
    apb_write_data = '0;
    repeat (3) @(negedge PCLK);
    check("reset_state", 32'(dut.state_q), 32'(IDLE));
    check("reset_out", 32'(apb_read_data_out), 32'h0);
    check("reset_bus", {29'd0, dut.psel1, dut.psel2, dut.penable}, 32'd0);
    PRESETn = 1'b1;

    // 1: read after reset
    single_xfer("t1_rd", 1'b0, 9'h005, 8'h00, 8'h00);
    // 2: write/read slave 1
    single_xfer("t2_wr", 1'b1, 9'h0A5, 8'h3C, 8'h00);
    single_xfer("t2_rd", 1'b0, 9'h0A5, 8'h00, 8'h3C);
    // 3: slave 2, no aliasing with slave 1
    single_xfer("t3_wr", 1'b1, 9'h1A5, 8'h5A, 8'h00);
    single_xfer("t3_rd2", 1'b0, 9'h1A5, 8'h00, 8'h5A);
    single_xfer("t3_rd1", 1'b0, 9'h0A5, 8'h00, 8'h3C);

    // 4: back-to-back writes then back-to-back reads
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge PCLK);
      drive_req(pass == 0, 9'h010, b2b_data[0], b2b_data[0]);
      for (int i = 0; i < 4; i++) begin
        @(posedge PCLK);
        @(negedge PCLK);
        check("b2b_setup_state", 32'(dut.state_q), 32'(SETUP));
        if (i < 3) drive_req(pass == 0, 9'(9'h010 + i + 1), b2b_data[i+1], b2b_data[i+1]);
        else transfer = 1'b0;
        @(negedge PCLK);
        check("b2b_access_state", 32'(dut.state_q), 32'(ACCESS));
      end
      @(negedge PCLK);
      check("b2b_end_state", 32'(dut.state_q), 32'(IDLE));
    end

    // 6: a write after a read leaves the read output alone
    single_xfer("t6_wr", 1'b1, 9'h030, 8'h99, 8'h00);
    check("t6_hold_out", 32'(apb_read_data_out), 32'h44);
    repeat (2) @(negedge PCLK);
    check("t6_idle_hold", 32'(apb_read_data_out), 32'h44);

    // 5: reset in the middle of SETUP of a write
    @(negedge PCLK);
    drive_req(1'b1, 9'h020, 8'hFF, 8'h00);
    @(posedge PCLK);
    @(negedge PCLK);
    transfer = 1'b0;
    check("t5_pre_state", 32'(dut.state_q), 32'(SETUP));
    PRESETn = 1'b0;
    #1;
    check("t5_rst_state", 32'(dut.state_q), 32'(IDLE));
    check("t5_rst_out", 32'(apb_read_data_out), 32'h0);
    check("t5_rst_bus", {29'd0, dut.psel1, dut.psel2, dut.penable}, 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    single_xfer("t5_rd", 1'b0, 9'h020, 8'h00, 8'h00);
    // Reset also cleared the earlier slave-1 data.
    single_xfer("t5_rd_clr", 1'b0, 9'h0A5, 8'h00, 8'h00);
    single_xfer("t5_rd_clr2", 1'b0, 9'h1A5, 8'h00, 8'h00);

    // ---------------- final report ----------------
    repeat (3) @(negedge PCLK);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
